// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle MIPS-I subset core.
// Holds the opcode and funct encodings, the HALT instruction word and the
// ALU operation enum used by both the core and its ALU.
package cpu_pkg;

  // Primary opcodes (inst[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (inst[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // All-ones word stops the core until the next reset
  localparam logic [31:0] HALT_INST = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

endpackage

// File: rtl/cpu_alu.sv
// Combinational 32-bit ALU for the cpu core.
// Ports:
//   a, b    - 32-bit operands
//   op      - operation select (alu_op_e)
//   result  - 32-bit wrap-around result; slt yields 0/1 from a signed compare
//   zero    - high when result is all zeros (used for beq)
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     op,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    result = '0;
    unique case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {31'd0, $signed(a) < $signed(b)};
      default: result = '0;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/cpu.sv
// Single-cycle MIPS-I subset core: add, sub, and, or, slt, addi, lw, sw,
// beq, j, plus the all-ones HALT word. Instruction memory is external and
// zero-latency; data memory is internal and is not cleared by reset.
// Optional feature macro: CPU_ILLEGAL_CHK_EN - when defined, an unsupported
// instruction sets err and done and halts; otherwise it runs as a NOP and
// err is tied low.
// Ports:
//   clk      - single clock, rising edge
//   reset    - synchronous, active-low
//   pcEn     - 1 retires one instruction this cycle, 0 freezes all state
//   pc       - byte address of the next instruction
//   inst     - instruction word at pc
//   wb_en    - previous retired instruction wrote a register
//   wb_addr  - destination register of that write
//   wb_data  - value written
//   done     - sticky HALT indicator
//   err      - sticky illegal-instruction indicator
module cpu
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcEn,
  output logic [31:0] pc,
  input  logic [31:0] inst,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        done,
  output logic        err
);

  localparam int AW = $clog2(DMEM_WORDS);

  logic [31:0] pc_q, pc_d;
  logic        done_q, done_d;
  logic        wb_en_q, wb_en_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
`ifdef CPU_ILLEGAL_CHK_EN
  logic        err_q, err_d;
`endif

  logic [31:0] rf_q [32];
  logic [31:0] dmem [DMEM_WORDS];

  // Instruction fields
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext;
  assign opcode   = inst[31:26];
  assign rs       = inst[25:21];
  assign rt       = inst[20:16];
  assign rd       = inst[15:11];
  assign funct    = inst[5:0];
  assign imm_sext = {{16{inst[15]}}, inst[15:0]};

  // Decode results
  alu_op_e     alu_op;
  logic        use_imm, wr_req, mem_rd, mem_wr, is_beq, is_j, legal;
  logic [4:0]  rf_dst;

  always_comb begin
    alu_op  = ALU_ADD;
    use_imm = 1'b0;
    wr_req  = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    is_beq  = 1'b0;
    is_j    = 1'b0;
    legal   = 1'b1;
    rf_dst  = rd;
    case (opcode)
      OP_RTYPE: begin
        wr_req = 1'b1;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: begin
            legal  = 1'b0;
            wr_req = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin
        use_imm = 1'b1;
        wr_req  = 1'b1;
        rf_dst  = rt;
      end
      OP_LW: begin
        use_imm = 1'b1;
        wr_req  = 1'b1;
        mem_rd  = 1'b1;
        rf_dst  = rt;
      end
      OP_SW: begin
        use_imm = 1'b1;
        mem_wr  = 1'b1;
      end
      OP_BEQ: begin
        alu_op = ALU_SUB;
        is_beq = 1'b1;
      end
      OP_J:    is_j  = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // Register 0 is never written, so reading it always returns zero
  logic [31:0] rs_val, rt_val, alu_result, wr_data, dmem_rdata;
  logic        alu_zero;
  logic [AW-1:0] mem_idx;
  assign rs_val = rf_q[rs];
  assign rt_val = rf_q[rt];

  cpu_alu u_alu (
    .a      (rs_val),
    .b      (use_imm ? imm_sext : rt_val),
    .op     (alu_op),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // Upper address bits are dropped so out-of-range addresses wrap
  assign mem_idx    = alu_result[AW+1:2];
  assign dmem_rdata = dmem[mem_idx];
  assign wr_data    = mem_rd ? dmem_rdata : alu_result;

  logic [31:0] pc_plus4, branch_target, jump_target;
  assign pc_plus4      = pc_q + 32'd4;
  assign branch_target = pc_plus4 + {imm_sext[29:0], 2'b00};
  assign jump_target   = {pc_plus4[31:28], inst[25:0], 2'b00};

  logic rf_we, mem_we;

  // HALT is checked before legality because its opcode is otherwise unused
  always_comb begin
    pc_d      = pc_q;
    done_d    = done_q;
    wb_en_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    rf_we     = 1'b0;
    mem_we    = 1'b0;
`ifdef CPU_ILLEGAL_CHK_EN
    err_d     = err_q;
`endif
    if (pcEn && !done_q) begin
      if (inst == HALT_INST) begin
        done_d = 1'b1;
      end else if (!legal) begin
`ifdef CPU_ILLEGAL_CHK_EN
        err_d  = 1'b1;
        done_d = 1'b1;
`else
        pc_d   = pc_plus4;
`endif
      end else begin
        if (is_j)
          pc_d = jump_target;
        else if (is_beq && alu_zero)
          pc_d = branch_target;
        else
          pc_d = pc_plus4;
        mem_we = mem_wr;
        if (wr_req && (rf_dst != 5'd0)) begin
          rf_we     = 1'b1;
          wb_en_d   = 1'b1;
          wb_addr_d = rf_dst;
          wb_data_d = wr_data;
        end
      end
    end
  end

  // Architectural state; reset wins over everything and drops the write
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      done_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
`ifdef CPU_ILLEGAL_CHK_EN
      err_q     <= 1'b0;
`endif
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      pc_q      <= pc_d;
      done_q    <= done_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
`ifdef CPU_ILLEGAL_CHK_EN
      err_q     <= err_d;
`endif
      if (rf_we) rf_q[rf_dst] <= wr_data;
    end
  end

  // Data memory keeps its contents across reset
  always_ff @(posedge clk) begin
    if (reset && mem_we) dmem[mem_idx] <= rt_val;
  end

  assign pc      = pc_q;
  assign done    = done_q;
  assign wb_en   = wb_en_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;
`ifdef CPU_ILLEGAL_CHK_EN
  assign err     = err_q;
`else
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for the cpu core: a vector table plus hand-written
// multi-cycle sequences, checked through an expected-result queue.
module tb_cpu;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcEn;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        done;
  logic        err;

  int n_vec  = 0;
  int n_miss = 0;

  cpu #(.RESET_PC(32'h0000_0000), .DMEM_WORDS(64)) dut (
    .clk     (clk),
    .reset   (reset),
    .pcEn    (pcEn),
    .pc      (pc),
    .inst    (inst),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        en;
    logic [31:0] inst;
    logic [31:0] exp_pc;
    logic        exp_we;
    logic [4:0]  exp_wa;
    logic [31:0] exp_wd;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  vec_t sb_q[$];
  vec_t tbl[$];

  function automatic vec_t mk(input logic rst_n, input logic en,
                              input logic [31:0] i, input logic [31:0] p,
                              input logic we, input logic [4:0] wa,
                              input logic [31:0] wd, input logic dn,
                              input logic er);
    vec_t v;
    v.rst_n = rst_n; v.en = en; v.inst = i; v.exp_pc = p;
    v.exp_we = we; v.exp_wa = wa; v.exp_wd = wd;
    v.exp_done = dn; v.exp_err = er;
    return v;
  endfunction

  task automatic checkOutput();
    vec_t e;
    if (sb_q.size() == 0) begin
      n_vec++; n_miss++;
      $display("[TB] FAIL scoreboard_empty got 0 entries required 1");
      return;
    end
    e = sb_q.pop_front();
    n_vec++;
    if (pc !== e.exp_pc) begin
      n_miss++;
      $display("[TB] FAIL pc inst=%h got %h required %h", e.inst, pc, e.exp_pc);
    end
    n_vec++;
    if (wb_en !== e.exp_we) begin
      n_miss++;
      $display("[TB] FAIL wb_en inst=%h got %b required %b", e.inst, wb_en, e.exp_we);
    end
    if (e.exp_we) begin
      n_vec++;
      if (wb_addr !== e.exp_wa) begin
        n_miss++;
        $display("[TB] FAIL wb_addr inst=%h got %0d required %0d", e.inst, wb_addr, e.exp_wa);
      end
      n_vec++;
      if (wb_data !== e.exp_wd) begin
        n_miss++;
        $display("[TB] FAIL wb_data inst=%h got %h required %h", e.inst, wb_data, e.exp_wd);
      end
    end
    n_vec++;
    if (done !== e.exp_done) begin
      n_miss++;
      $display("[TB] FAIL done inst=%h got %b required %b", e.inst, done, e.exp_done);
    end
    n_vec++;
    if (err !== e.exp_err) begin
      n_miss++;
      $display("[TB] FAIL err inst=%h got %b required %b", e.inst, err, e.exp_err);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    reset = v.rst_n;
    pcEn  = v.en;
    inst  = v.inst;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  initial begin
    reset = 1'b0;
    pcEn  = 1'b0;
    inst  = 32'd0;

    // Reset, then straight-line arithmetic, memory, branches and jump
    tbl.push_back(mk(0, 1, 32'h2001_0005, 32'h00, 0, 0, 0,            0, 0));
    tbl.push_back(mk(1, 1, 32'h2001_0005, 32'h04, 1, 1, 32'h5,        0, 0)); // addi $1,$0,5
    tbl.push_back(mk(1, 1, 32'h2002_0007, 32'h08, 1, 2, 32'h7,        0, 0)); // addi $2,$0,7
    tbl.push_back(mk(1, 1, 32'h0022_1822, 32'h0C, 1, 3, 32'hFFFF_FFFE, 0, 0)); // sub $3,$1,$2
    tbl.push_back(mk(1, 1, 32'h0022_202A, 32'h10, 1, 4, 32'h1,        0, 0)); // slt $4,$1,$2
    tbl.push_back(mk(1, 1, 32'h0022_3020, 32'h14, 1, 6, 32'hC,        0, 0)); // add $6,$1,$2
    tbl.push_back(mk(1, 1, 32'h0022_3824, 32'h18, 1, 7, 32'h5,        0, 0)); // and $7,$1,$2
    tbl.push_back(mk(1, 1, 32'h0022_4025, 32'h1C, 1, 8, 32'h7,        0, 0)); // or $8,$1,$2
    tbl.push_back(mk(1, 1, 32'hAC01_0000, 32'h20, 0, 0, 0,            0, 0)); // sw $1,0($0)
    tbl.push_back(mk(1, 1, 32'h8C05_0000, 32'h24, 1, 5, 32'h5,        0, 0)); // lw $5,0($0)
    tbl.push_back(mk(1, 1, 32'h8C09_0100, 32'h28, 1, 9, 32'h5,        0, 0)); // lw $9,256($0) aliases word 0
    tbl.push_back(mk(1, 1, 32'hAC02_0104, 32'h2C, 0, 0, 0,            0, 0)); // sw $2,0x104($0) -> word 1
    tbl.push_back(mk(1, 1, 32'h8C0A_0004, 32'h30, 1, 10, 32'h7,       0, 0)); // lw $10,4($0)
    tbl.push_back(mk(1, 1, 32'h2000_0009, 32'h34, 0, 0, 0,            0, 0)); // addi $0,$0,9
    tbl.push_back(mk(1, 1, 32'h0000_5825, 32'h38, 1, 11, 32'h0,       0, 0)); // or $11,$0,$0
    tbl.push_back(mk(1, 1, 32'h202C_FFFA, 32'h3C, 1, 12, 32'hFFFF_FFFF, 0, 0)); // addi $12,$1,-6
    tbl.push_back(mk(1, 1, 32'h1022_0004, 32'h40, 0, 0, 0,            0, 0)); // beq $1,$2 not taken
    tbl.push_back(mk(1, 1, 32'h1025_0002, 32'h4C, 0, 0, 0,            0, 0)); // beq $1,$5,+2 taken
    tbl.push_back(mk(1, 1, 32'h0800_0010, 32'h40, 0, 0, 0,            0, 0)); // j 0x10

    for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i]);

    // Mid-program reset drops the addi; memory survives reset
    applyStimulus(mk(0, 1, 32'h2001_0077, 32'h00, 0, 0, 0,  0, 0));
    applyStimulus(mk(1, 1, 32'h0001_6825, 32'h04, 1, 13, 0, 0, 0));  // or $13,$0,$1
    applyStimulus(mk(1, 1, 32'h8C0E_0000, 32'h08, 1, 14, 5, 0, 0));  // lw $14,0($0)
    // beq $0,$0,-1 at pc 8 spins in place
    applyStimulus(mk(1, 1, 32'h1000_FFFF, 32'h08, 0, 0, 0,  0, 0));
    // Three frozen cycles: pc holds and the addi must not land in $1
    for (int i = 0; i < 3; i++)
      applyStimulus(mk(1, 0, 32'h2001_0033, 32'h08, 0, 0, 0, 0, 0));
    applyStimulus(mk(1, 1, 32'h0001_7825, 32'h0C, 1, 15, 0, 0, 0));  // or $15,$0,$1
    // HALT at pc 0xC, then nothing moves even with pcEn high
    applyStimulus(mk(1, 1, HALT,          32'h0C, 0, 0, 0,  1, 0));
    applyStimulus(mk(1, 1, 32'h2002_0001, 32'h0C, 0, 0, 0,  1, 0));
    applyStimulus(mk(1, 1, 32'h2002_0001, 32'h0C, 0, 0, 0,  1, 0));
    // Reset beats HALT and pcEn in the same cycle
    applyStimulus(mk(0, 1, HALT,          32'h00, 0, 0, 0,  0, 0));

    // Unsupported opcode 3F (not HALT), then an addi
`ifdef CPU_ILLEGAL_CHK_EN
    applyStimulus(mk(1, 1, 32'hFC00_0000, 32'h00, 0, 0, 0,  1, 1));
    applyStimulus(mk(1, 1, 32'h2001_0003, 32'h00, 0, 0, 0,  1, 1));
`else
    applyStimulus(mk(1, 1, 32'hFC00_0000, 32'h04, 0, 0, 0,  0, 0));
    applyStimulus(mk(1, 1, 32'h2001_0003, 32'h08, 1, 1, 3,  0, 0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
